// File: rtl/pc_pkg.sv
// pc_pkg: shared FSM state encodings and sizing helpers for the PC unit
package pc_pkg;
  localparam logic [0:0] PC_IDLE = 1'b0;
  localparam logic [0:0] PC_HOLD = 1'b1;
  localparam int DEF_INSTR_BYTES = 2;
  function automatic int ras_cnt_w(int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address LIFO; a push when full overwrites the oldest entry
module ras_stack import pc_pkg::*; #(
  parameter int ADDR_W = 16,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = ras_cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic [CW-1:0]     cnt,
  output logic              ovf,
  output logic              unf
);
  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_d [DEPTH];
  logic [PW-1:0] tp_q, tp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic empty, full;
  assign empty = cnt_q == '0;
  assign full = cnt_q == CW'(DEPTH);
  assign top = empty ? '0 : mem_q[tp_q];
  assign cnt = cnt_q;
  assign ovf = push & !pop & full;
  assign unf = pop & empty;
  always_comb begin
    mem_d = mem_q;
    tp_d = tp_q;
    cnt_d = cnt_q;
    if (push & pop & !empty) mem_d[tp_q] = push_data;
    else if (push) begin
      tp_d = tp_q + 1'b1;
      mem_d[tp_d] = push_data;
      cnt_d = full ? cnt_q : cnt_q + 1'b1;
    end else if (pop & !empty) begin
      tp_d = tp_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
    if (flush) cnt_d = '0;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      mem_q <= '{default: '0};
      tp_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      tp_q <= tp_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/pc_unit_ras.sv
// pc_unit_ras: next-PC selection with return-address stack, sticky RAS flags and post-write hold
module pc_unit_ras import pc_pkg::*; #(
  parameter int ADDR_W = 16,
  parameter int RAS_DEPTH = 4,
  parameter int INSTR_BYTES = DEF_INSTR_BYTES,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int CW = ras_cnt_w(RAS_DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pc_adv,
  input  logic              br,
  input  logic              link,
  input  logic              ret,
  input  logic [ADDR_W-1:0] offset,
  input  logic              pc_wr,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              ras_flush,
  input  logic              flag_clr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] lr,
  output logic [CW-1:0]     ras_cnt,
  output logic              ras_ovf,
  output logic              ras_unf,
  output logic              hold
);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] BBASE = ADDR_W'(2 * INSTR_BYTES);
  logic [0:0] state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, top;
  logic ovf_q, ovf_d, unf_q, unf_d, ovf_ev, unf_ev;
  logic adv, wr, do_ret, have;
  assign adv = (state_q == PC_IDLE) & pc_adv;
  assign wr = (state_q == PC_IDLE) & pc_wr & !pc_adv;
  assign do_ret = adv & ret;
  assign have = ras_cnt != '0;
  ras_stack #(.ADDR_W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk), .resetn(resetn), .push(adv & link), .pop(do_ret), .flush(ras_flush),
    .push_data(pc_q + STEP), .top(top), .cnt(ras_cnt), .ovf(ovf_ev), .unf(unf_ev)
  );
  // Multiply truncates to ADDR_W, so a negative offset wraps correctly
  always_comb begin
    pc_d = do_ret & have ? top :
           do_ret ? pc_q + STEP :
           adv & br ? pc_q + offset * STEP + BBASE :
           adv ? pc_q + STEP :
           wr ? data_in : pc_q;
    state_d = wr ? PC_HOLD : PC_IDLE;
    ovf_d = ovf_ev | (ovf_q & !flag_clr);
    unf_d = unf_ev | (unf_q & !flag_clr);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= PC_IDLE;
      pc_q <= RESET_PC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  assign pc = pc_q;
  assign lr = top;
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;
  assign hold = state_q == PC_HOLD;
endmodule

// File: tb/tb_pc_unit_ras.sv
// tb_pc_unit_ras: directed vector table plus hand-written reset sequences for pc_unit_ras
module tb_pc_unit_ras;
  logic clk = 1'b0, resetn = 1'b0;
  logic pc_adv = 0, br = 0, link = 0, ret = 0, pc_wr = 0, ras_flush = 0, flag_clr = 0;
  logic [15:0] offset = '0, data_in = '0;
  logic [15:0] pc, lr;
  logic [2:0] ras_cnt;
  logic ras_ovf, ras_unf, hold;
  int errors = 0, checks = 0;

  pc_unit_ras #(.ADDR_W(16), .RAS_DEPTH(4), .INSTR_BYTES(2), .RESET_PC(16'h0)) dut (
    .clk(clk), .resetn(resetn), .pc_adv(pc_adv), .br(br), .link(link), .ret(ret),
    .offset(offset), .pc_wr(pc_wr), .data_in(data_in), .ras_flush(ras_flush),
    .flag_clr(flag_clr), .pc(pc), .lr(lr), .ras_cnt(ras_cnt), .ras_ovf(ras_ovf),
    .ras_unf(ras_unf), .hold(hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic adv, br, link, ret, wr;
    logic [15:0] data, off;
    logic fl, fc;
    logic [15:0] e_pc, e_lr;
    logic [2:0] e_cnt;
    logic e_ovf, e_unf, e_hold;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(logic a, logic b, logic l, logic r, logic w, logic [15:0] d,
                              logic [15:0] o, logic fl, logic fc, logic [15:0] p,
                              logic [15:0] lrv, logic [2:0] c, logic ov, logic un, logic h);
    vec_t v;
    v.adv = a; v.br = b; v.link = l; v.ret = r; v.wr = w; v.data = d; v.off = o;
    v.fl = fl; v.fc = fc; v.e_pc = p; v.e_lr = lrv; v.e_cnt = c; v.e_ovf = ov;
    v.e_unf = un; v.e_hold = h;
    return v;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [15:0] p, logic [15:0] lrv, logic [2:0] c,
                         logic ov, logic un, logic h);
    chk({tag, " pc"}, pc, p);
    chk({tag, " lr"}, lr, lrv);
    chk({tag, " ras_cnt"}, 16'(ras_cnt), 16'(c));
    chk({tag, " ras_ovf"}, 16'(ras_ovf), 16'(ov));
    chk({tag, " ras_unf"}, 16'(ras_unf), 16'(un));
    chk({tag, " hold"}, 16'(hold), 16'(h));
  endtask

  initial begin
    //          adv br lk rt wr data      off       fl fc  pc        lr        cnt ov un h
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0,    16'h0,    0, 0, 16'h0002, 16'h0,    0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0,    16'h0,    0, 0, 16'h0004, 16'h0,    0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0,    16'h0,    0, 0, 16'h0006, 16'h0,    0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0010, 16'h0,    0, 0, 16'h0010, 16'h0,    0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0,    16'h0,    0, 0, 16'h0010, 16'h0,    0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 16'h0,    16'hFFFE, 0, 0, 16'h0010, 16'h0,    0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 16'h0,    16'h0005, 0, 0, 16'h001E, 16'h0,    0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0020, 16'h0,    0, 0, 16'h0020, 16'h0,    0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0,    16'h0,    0, 0, 16'h0020, 16'h0,    0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 16'h0,    16'h0008, 0, 0, 16'h0034, 16'h0022, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 16'h0,    16'h0,    0, 0, 16'h0022, 16'h0,    0, 0, 0, 0));
    for (int k = 1; k <= 5; k++) begin
      logic [15:0] base;
      base = 16'(k) << 8;
      vecs.push_back(mk(0, 0, 0, 0, 1, base, 16'h0, 0, 0, base, k == 1 ? 16'h0 : base - 16'h00FE,
                        3'(k - 1 > 4 ? 4 : k - 1), 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, base, k == 1 ? 16'h0 : base - 16'h00FE,
                        3'(k - 1 > 4 ? 4 : k - 1), 0, 0, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 16'h0, 16'h0, 0, 0, base + 16'h2, base + 16'h2,
                        3'(k > 4 ? 4 : k), k == 5, 0, 0));
    end
    vecs.push_back(mk(1, 0, 0, 1, 0, 16'h0,    16'h0,    0, 0, 16'h0502, 16'h0402, 3, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 16'h0,    16'h0,    0, 0, 16'h0402, 16'h0302, 2, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 16'h0,    16'h0,    0, 0, 16'h0302, 16'h0202, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 16'h0,    16'h0,    0, 0, 16'h0202, 16'h0,    0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 16'h0,    16'h0,    0, 0, 16'h0204, 16'h0,    0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0,    16'h0,    0, 1, 16'h0204, 16'h0,    0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'hBEEF, 16'h0,    0, 0, 16'hBEEF, 16'h0,    0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0,    16'h0,    0, 0, 16'hBEEF, 16'h0,    0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0,    16'h0,    0, 0, 16'hBEF1, 16'h0,    0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0040, 16'h0,    0, 0, 16'h0040, 16'h0,    0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0,    16'h0,    0, 0, 16'h0040, 16'h0,    0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 16'h1234, 16'h0,    0, 0, 16'h0042, 16'h0,    0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 16'h0,    16'h0,    0, 0, 16'h0044, 16'h0044, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 16'h0,    16'h0,    0, 0, 16'h0044, 16'h0046, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 16'h0,    16'h0,    0, 0, 16'h0046, 16'h0,    0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 16'h0,    16'h0,    0, 0, 16'h0048, 16'h0048, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 16'h0,    16'h0,    1, 0, 16'h004A, 16'h0,    0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 16'h0,    16'h0,    0, 1, 16'h004C, 16'h0,    0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0,    16'h0,    0, 1, 16'h004C, 16'h0,    0, 0, 0, 0));

    #2;
    chk_all("reset", 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      pc_adv = vecs[i].adv; br = vecs[i].br; link = vecs[i].link; ret = vecs[i].ret;
      pc_wr = vecs[i].wr; data_in = vecs[i].data; offset = vecs[i].off;
      ras_flush = vecs[i].fl; flag_clr = vecs[i].fc;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_lr, vecs[i].e_cnt,
              vecs[i].e_ovf, vecs[i].e_unf, vecs[i].e_hold);
    end

    // Call then write, then async reset mid-HOLD must clear everything at once
    @(negedge clk);
    pc_adv = 1; link = 1; pc_wr = 0; ret = 0; br = 0; ras_flush = 0; flag_clr = 0;
    @(negedge clk);
    pc_adv = 0; link = 0; pc_wr = 1; data_in = 16'h0077;
    @(posedge clk);
    #1;
    chk_all("wr before reset", 16'h0077, 16'h004E, 3'd1, 1'b0, 1'b0, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    chk_all("async reset", 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    pc_wr = 0;
    @(negedge clk);
    resetn = 1'b1;
    pc_adv = 1;
    @(posedge clk);
    #1;
    chk_all("after reset", 16'h0002, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    pc_adv = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
